// File: rtl/reg_stream_pkg.sv
// Shared definitions for the register-access byte stream (transmit and receive sides).
// Optional feature: CHECKSUM_EN adds a trailing checksum field to each packet.
package reg_stream_pkg;

   // Framing constants
   localparam logic [7:0] SYNC_BYTE = 8'h55;
   localparam logic [7:0] CMD_RD    = 8'h01;
   localparam logic [7:0] CMD_WR    = 8'h02;

   // One byte on the stream, with its framing flags
   typedef struct packed {
      logic [7:0] Data;
      logic       Valid;
      logic       SoP;
      logic       EoP;
   } stream_byte_t;

   // Packet field currently being sent or parsed
   typedef enum logic [2:0] {
      IDLE,
      SEND_SYNC,
      SEND_CMD,
      SEND_LENGTH,
      SEND_ADDRESS,
      SEND_DATA
`ifdef CHECKSUM_EN
      , SEND_CHECKSUM
`endif
   } packet_field_t;

endpackage

// File: rtl/stream_checksum.sv
// Running 8-bit sum of stream bytes: cleared by the SoP byte, accumulated on every
// other handshake. opSumNext already includes the byte currently being handshaked.
module stream_checksum
   import reg_stream_pkg::*;
(
   input  logic       ipClk,
   input  logic       reset,
   input  logic [7:0] ipByte,
   input  logic       ipSoP,
   input  logic       ipHandshake,
   output logic [7:0] opSumNext
);

   logic [7:0] sum_q;

   // Sum including the byte on the bus, so the checksum byte can be loaded in one edge
   always_comb begin
      opSumNext = sum_q + ipByte;
   end

   // Restart on the sync byte (excluded from the sum), accumulate everything after it
   always_ff @(posedge ipClk) begin
      if (reset) begin
         sum_q <= '0;
      end else if (ipHandshake) begin
         if (ipSoP) begin
            sum_q <= '0;
         end else begin
            sum_q <= opSumNext;
         end
      end
   end

endmodule

// File: rtl/reg_tx_packetiser.sv
// Frames one register read response as SYNC, CMD, LENGTH, ADDRESS, DATA (MSB first)
// and streams it out under ipTxReady back-pressure.
// Optional feature: CHECKSUM_EN appends a sum-mod-256 byte (sync excluded) carrying EoP.
module reg_tx_packetiser
   import reg_stream_pkg::*;
#(
   parameter int unsigned DATA_LENGTH = 4,
   parameter logic [7:0]  SYNC        = SYNC_BYTE,
   parameter logic [7:0]  RD_CMD      = CMD_RD
)(
   input  logic                     ipClk,
   input  logic                     reset,
   input  logic                     ipRdValid,
   input  logic [7:0]               ipRdAddress,
   input  logic [8*DATA_LENGTH-1:0] ipRdData,
   output logic                     opRdReady,
   output logic [7:0]               opTxData,
   output logic                     opTxValid,
   output logic                     opTxSoP,
   output logic                     opTxEoP,
   input  logic                     ipTxReady
);

   localparam int unsigned CW = (DATA_LENGTH > 1) ? $clog2(DATA_LENGTH) : 1;

`ifdef CHECKSUM_EN
   localparam logic DATA_ENDS_PACKET = 1'b0;
`else
   localparam logic DATA_ENDS_PACKET = 1'b1;
`endif

   packet_field_t                 state_q;
   stream_byte_t                  tx_q;
   logic                          rdy_q;
   logic [CW-1:0]                 count_q;
   logic [CW-1:0]                 count_dec;
   logic [7:0]                    addr_q;
   logic [DATA_LENGTH-1:0][7:0]   data_q;
   logic                          hs;

   assign hs        = tx_q.Valid & ipTxReady;
   assign opRdReady = rdy_q;
   assign opTxData  = tx_q.Data;
   assign opTxValid = tx_q.Valid;
   assign opTxSoP   = tx_q.SoP;
   assign opTxEoP   = tx_q.EoP;

   // Index of the data byte that follows the one currently on the bus
   always_comb begin
      count_dec = count_q - 1'b1;
   end

`ifdef CHECKSUM_EN
   logic [7:0] chk_next;

   stream_checksum u_checksum (
      .ipClk       (ipClk),
      .reset       (reset),
      .ipByte      (tx_q.Data),
      .ipSoP       (tx_q.SoP),
      .ipHandshake (hs),
      .opSumNext   (chk_next)
   );
`endif

   // Packet FSM; every output byte is registered and only changes on a handshake
   always_ff @(posedge ipClk) begin
      if (reset) begin
         state_q <= IDLE;
         rdy_q   <= 1'b1;
         tx_q    <= '0;
         count_q <= '0;
         addr_q  <= '0;
         data_q  <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (ipRdValid) begin
                  addr_q  <= ipRdAddress;
                  data_q  <= ipRdData;
                  rdy_q   <= 1'b0;
                  tx_q    <= '{Data: SYNC, Valid: 1'b1, SoP: 1'b1, EoP: 1'b0};
                  state_q <= SEND_SYNC;
               end
            end
            SEND_SYNC: begin
               if (hs) begin
                  tx_q    <= '{Data: RD_CMD, Valid: 1'b1, SoP: 1'b0, EoP: 1'b0};
                  state_q <= SEND_CMD;
               end
            end
            SEND_CMD: begin
               if (hs) begin
                  tx_q    <= '{Data: DATA_LENGTH[7:0], Valid: 1'b1, SoP: 1'b0, EoP: 1'b0};
                  state_q <= SEND_LENGTH;
               end
            end
            SEND_LENGTH: begin
               if (hs) begin
                  tx_q    <= '{Data: addr_q, Valid: 1'b1, SoP: 1'b0, EoP: 1'b0};
                  state_q <= SEND_ADDRESS;
               end
            end
            SEND_ADDRESS: begin
               if (hs) begin
                  count_q <= CW'(DATA_LENGTH - 1);
                  tx_q    <= '{Data: data_q[DATA_LENGTH-1], Valid: 1'b1, SoP: 1'b0,
                              EoP: DATA_ENDS_PACKET && (DATA_LENGTH == 1)};
                  state_q <= SEND_DATA;
               end
            end
            SEND_DATA: begin
               if (hs) begin
                  if (count_q == '0) begin
`ifdef CHECKSUM_EN
                     tx_q    <= '{Data: chk_next, Valid: 1'b1, SoP: 1'b0, EoP: 1'b1};
                     state_q <= SEND_CHECKSUM;
`else
                     tx_q    <= '0;
                     rdy_q   <= 1'b1;
                     state_q <= IDLE;
`endif
                  end else begin
                     count_q <= count_dec;
                     tx_q    <= '{Data: data_q[count_dec], Valid: 1'b1, SoP: 1'b0,
                                 EoP: DATA_ENDS_PACKET && (count_dec == '0)};
                  end
               end
            end
`ifdef CHECKSUM_EN
            SEND_CHECKSUM: begin
               if (hs) begin
                  tx_q    <= '0;
                  rdy_q   <= 1'b1;
                  state_q <= IDLE;
               end
            end
`endif
            default: begin
               tx_q    <= '0;
               rdy_q   <= 1'b1;
               state_q <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_reg_tx_packetiser.sv
// Scoreboard bench for reg_tx_packetiser: the driver pushes expected packet bytes,
// an independent monitor pops and compares them on every stream handshake.
module tb_reg_tx_packetiser;

   localparam int unsigned DL = 4;
`ifdef CHECKSUM_EN
   localparam int unsigned PKT = 5 + DL;
`else
   localparam int unsigned PKT = 4 + DL;
`endif

   logic            ipClk = 1'b0;
   logic            reset;
   logic            ipRdValid;
   logic [7:0]      ipRdAddress;
   logic [8*DL-1:0] ipRdData;
   logic            opRdReady;
   logic [7:0]      opTxData;
   logic            opTxValid;
   logic            opTxSoP;
   logic            opTxEoP;
   logic            ipTxReady;

   typedef struct packed {
      logic [7:0] d;
      logic       sop;
      logic       eop;
   } exp_t;

   exp_t        sb[$];
   int          compared   = 0;
   int          mismatched = 0;
   int          ready_mode = 0;

   reg_tx_packetiser #(.DATA_LENGTH(DL), .SYNC(8'h55), .RD_CMD(8'h01)) dut (
      .ipClk       (ipClk),
      .reset       (reset),
      .ipRdValid   (ipRdValid),
      .ipRdAddress (ipRdAddress),
      .ipRdData    (ipRdData),
      .opRdReady   (opRdReady),
      .opTxData    (opTxData),
      .opTxValid   (opTxValid),
      .opTxSoP     (opTxSoP),
      .opTxEoP     (opTxEoP),
      .ipTxReady   (ipTxReady)
   );

   always #5 ipClk = ~ipClk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference packet: list of bytes built from the framing rules
   task automatic push_packet(input logic [7:0] a, input logic [8*DL-1:0] d);
      logic [7:0]  bytes[$];
      int unsigned sum;
      bytes = '{8'h55, 8'h01, 8'(DL), a};
      for (int i = DL - 1; i >= 0; i--) bytes.push_back(d[8*i +: 8]);
`ifdef CHECKSUM_EN
      sum = 0;
      for (int i = 1; i < bytes.size(); i++) sum += bytes[i];
      bytes.push_back(8'(sum % 256));
`endif
      for (int i = 0; i < bytes.size(); i++)
         sb.push_back('{d: bytes[i], sop: (i == 0), eop: (i == bytes.size() - 1)});
   endtask

   function automatic logic [8*DL-1:0] rand_data();
      logic [8*DL-1:0] v;
      for (int i = 0; i < DL; i++) v[8*i +: 8] = 8'($urandom_range(0, 255));
      return v;
   endfunction

   // Downstream ready generator: 0 always ready, 1 pattern 1,0,0, 2 random, 3 never
   initial begin
      int unsigned phase = 0;
      ipTxReady = 1'b0;
      forever begin
         @(posedge ipClk);
         #1;
         case (ready_mode)
            0: ipTxReady = 1'b1;
            1: ipTxReady = (phase == 0);
            2: ipTxReady = 1'($urandom_range(0, 1));
            default: ipTxReady = 1'b0;
         endcase
         phase = (phase + 1) % 3;
      end
   end

   // Monitor: compare each handshaked byte with the scoreboard; check held bytes stay put
   initial begin
      exp_t       e;
      logic       pv = 1'b0;
      logic       pr = 1'b0;
      logic [9:0] pbyte = '0;
      forever begin
         @(negedge ipClk);
         if (reset) begin
            pv = 1'b0;
            continue;
         end
         if (pv && !pr)
            chk("hold", {opTxValid, opTxSoP, opTxEoP, opTxData}, {1'b1, pbyte});
         if (opTxValid && opRdReady)
            chk("ready_while_valid", 32'(opRdReady), 32'd0);
         if (opTxValid && ipTxReady) begin
            if (sb.size() == 0) begin
               compared++;
               mismatched++;
               $display("FAIL unexpected_byte: got %h expected none", opTxData);
            end else begin
               e = sb.pop_front();
               chk("byte", {opTxSoP, opTxEoP, opTxData}, {e.sop, e.eop, e.d});
            end
         end
         pv    = opTxValid;
         pr    = ipTxReady;
         pbyte = {opTxSoP, opTxEoP, opTxData};
      end
   end

   // Offer one request, waiting (bounded) for opRdReady; returns one step after acceptance edge
   task automatic send(input logic [7:0] a, input logic [8*DL-1:0] d);
      int unsigned n = 0;
      while (!opRdReady && n < 300) begin
         @(posedge ipClk);
         #1;
         n++;
      end
      if (!opRdReady) begin
         compared++;
         mismatched++;
         $display("FAIL ready_timeout: got 0 expected 1");
      end
      ipRdValid   = 1'b1;
      ipRdAddress = a;
      ipRdData    = d;
      push_packet(a, d);
      @(posedge ipClk);
      #1;
      ipRdValid   = 1'b0;
      ipRdAddress = 8'($urandom_range(0, 255));
      ipRdData    = rand_data();
   endtask

   task automatic drain();
      int unsigned n = 0;
      while ((sb.size() != 0 || !opRdReady) && n < 1000) begin
         @(posedge ipClk);
         #1;
         n++;
      end
      chk("drain_outstanding", 32'(sb.size()), 32'd0);
   endtask

   initial begin
      reset       = 1'b1;
      ipRdValid   = 1'b0;
      ipRdAddress = '0;
      ipRdData    = '0;
      ready_mode  = 3;
      repeat (3) @(posedge ipClk);
      #1;
      reset = 1'b0;

      // Reset values then idle, with ready both low and high
      for (int i = 0; i < 10; i++) begin
         @(negedge ipClk);
         chk("idle_outputs", {opRdReady, opTxValid, opTxSoP, opTxEoP, opTxData},
             {1'b1, 1'b0, 1'b0, 1'b0, 8'h00});
         if (i == 4) ready_mode = 0;
      end
      @(posedge ipClk);
      #1;

      // Zero back-pressure: contiguous packet, ready returns the cycle after EoP
      ready_mode = 0;
      send(8'h12, 32'hDEADBEEF);
      for (int i = 0; i < PKT; i++) begin
         @(negedge ipClk);
         chk("contig_valid", {opTxValid, opRdReady}, {1'b1, 1'b0});
      end
      @(negedge ipClk);
      chk("ready_after_eop", {opRdReady, opTxValid}, {1'b1, 1'b0});
      drain();

      // Toggling back-pressure plus an ignored request during the packet
      ready_mode = 1;
      send(8'h12, 32'hDEADBEEF);
      @(posedge ipClk);
      #1;
      ipRdValid   = 1'b1;
      ipRdAddress = 8'h34;
      ipRdData    = 32'h01020304;
      repeat (2) @(posedge ipClk);
      #1;
      ipRdValid = 1'b0;
      drain();

      // Reset after the address byte: back to idle, then a full fresh packet
      ready_mode = 0;
      send(8'h12, 32'hDEADBEEF);
      repeat (4) @(posedge ipClk);
      #1;
      reset = 1'b1;
      @(negedge ipClk);
      @(negedge ipClk);
      chk("reset_mid_packet", {opRdReady, opTxValid, opTxSoP, opTxEoP, opTxData},
          {1'b1, 1'b0, 1'b0, 1'b0, 8'h00});
      sb.delete();
      @(posedge ipClk);
      #1;
      reset = 1'b0;
      send(8'h56, 32'hCAFEF00D);
      drain();

      // Randomized traffic under random back-pressure
      ready_mode = 2;
      for (int k = 0; k < 25; k++) begin
         send(8'($urandom_range(0, 255)), rand_data());
         if (k % 5 == 4) ready_mode = (ready_mode == 2) ? 0 : 2;
      end
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
